// File: rtl/mult_seq_pkg.sv
// Shared types and partial-product combine helpers for mult_cell_sequencer.
// MULT_SEQ_HI_EN adds the high-word pass states.
package mult_seq_pkg;

  localparam int unsigned CELL_W = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LO,
    S_WAIT_LO,
    S_RESP
`ifdef MULT_SEQ_HI_EN
    ,
    S_ISSUE_HI,
    S_WAIT_HI
`endif
  } state_e;

  // Cross terms are summed at 33 bits so the carry survives into the high word.
  function automatic logic [WORD_W-1:0] combine_lo(input logic [WORD_W-1:0] p1,
                                                   input logic [WORD_W-1:0] p2,
                                                   input logic [WORD_W-1:0] p3);
    logic [WORD_W:0] mid;
    mid = {1'b0, p2} + {1'b0, p3};
    return p1 + WORD_W'(mid << CELL_W);
  endfunction

  function automatic logic [WORD_W-1:0] combine_hi(input logic [WORD_W-1:0] phh,
                                                   input logic [WORD_W-1:0] p1,
                                                   input logic [WORD_W-1:0] p2,
                                                   input logic [WORD_W-1:0] p3);
    logic [WORD_W:0]     mid;
    logic [2*WORD_W-1:0] full;
    mid  = {1'b0, p2} + {1'b0, p3};
    full = {phh, {WORD_W{1'b0}}}
         + ({{(WORD_W-1){1'b0}}, mid} << CELL_W)
         + {{WORD_W{1'b0}}, p1};
    return WORD_W'(full >> WORD_W);
  endfunction

endpackage

// File: rtl/mult_cell_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant_o   = '0;
    win_idx_o = '0;
    found     = 1'b0;
    pos       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        win_idx_o    = pos;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (win_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/mult_cell_sequencer.sv
// Shares one 16x16 three-partial-product cell among NUM_REQ requesters.
// Define MULT_SEQ_HI_EN to build the second pass that returns the high product word.
module mult_cell_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned CELL_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_hi,
  input  logic [NUM_REQ*WORD_W-1:0]   req_a,
  input  logic [NUM_REQ*WORD_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [WORD_W-1:0]           rsp_data,
  output logic [WORD_W-1:0]           cell_src1,
  output logic [WORD_W-1:0]           cell_src2,
  output logic                        cell_en,
  input  logic [WORD_W-1:0]           cell_p1,
  input  logic [WORD_W-1:0]           cell_p2,
  input  logic [WORD_W-1:0]           cell_p3
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q;
  logic [1:0]         cnt_q;
  logic [IDX_W-1:0]   owner_q;
  logic               cell_en_q;
  logic [WORD_W-1:0]  cell_src1_q, cell_src2_q, rsp_data_q;
  logic [NUM_REQ-1:0] rsp_valid_q;

  logic [NUM_REQ-1:0] grant, own_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               is_idle, advance, wait_done;

`ifdef MULT_SEQ_HI_EN
  logic              hi_q;
  logic [CELL_W-1:0] a_hi_q, b_hi_q;
  logic [WORD_W-1:0] p1_q, p2_q, p3_q;
`else
  logic unused_hi;
  assign unused_hi = ^req_hi;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .req_i     (req_valid),
    .advance_i (advance),
    .grant_o   (grant),
    .win_idx_o (win_idx)
  );

  assign is_idle   = (state_q == S_IDLE);
  assign req_ready = (is_idle && reset_n) ? grant : '0;
  assign advance   = is_idle && (|(req_valid & grant));
  assign wait_done = (cnt_q == 2'(CELL_LAT - 1));

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
  end

  assign cell_en   = cell_en_q;
  assign cell_src1 = cell_src1_q;
  assign cell_src2 = cell_src2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= '0;
      cell_en_q   <= 1'b0;
      cell_src1_q <= '0;
      cell_src2_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef MULT_SEQ_HI_EN
      hi_q   <= 1'b0;
      a_hi_q <= '0;
      b_hi_q <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      p3_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (advance) begin
          // Operands go straight into the cell source registers; only the upper
          // halves need a separate copy for the high pass.
          owner_q     <= win_idx;
          cell_src1_q <= req_a[WORD_W*win_idx +: WORD_W];
          cell_src2_q <= req_b[WORD_W*win_idx +: WORD_W];
          cell_en_q   <= 1'b1;
`ifdef MULT_SEQ_HI_EN
          hi_q   <= req_hi[win_idx];
          a_hi_q <= req_a[WORD_W*win_idx + CELL_W +: CELL_W];
          b_hi_q <= req_b[WORD_W*win_idx + CELL_W +: CELL_W];
`endif
          state_q <= S_ISSUE_LO;
        end
        S_ISSUE_LO: begin
          cell_en_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT_LO;
        end
        S_WAIT_LO: if (wait_done) begin
`ifdef MULT_SEQ_HI_EN
          if (hi_q) begin
            p1_q        <= cell_p1;
            p2_q        <= cell_p2;
            p3_q        <= cell_p3;
            cell_src1_q <= {{(WORD_W-CELL_W){1'b0}}, a_hi_q};
            cell_src2_q <= {{(WORD_W-CELL_W){1'b0}}, b_hi_q};
            cell_en_q   <= 1'b1;
            state_q     <= S_ISSUE_HI;
          end else
`endif
          begin
            rsp_data_q  <= combine_lo(cell_p1, cell_p2, cell_p3);
            rsp_valid_q <= own_oh;
            state_q     <= S_RESP;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
`ifdef MULT_SEQ_HI_EN
        S_ISSUE_HI: begin
          cell_en_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= S_WAIT_HI;
        end
        S_WAIT_HI: if (wait_done) begin
          rsp_data_q  <= combine_hi(cell_p1, p1_q, p2_q, p3_q);
          rsp_valid_q <= own_oh;
          state_q     <= S_RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
`endif
        S_RESP: if (rsp_ready[owner_q]) begin
          rsp_valid_q <= '0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_cell_sequencer.sv
// Scoreboard bench for mult_cell_sequencer with a behavioural multiplier-cell model.
module tb_mult_cell_sequencer;

  localparam int NUM_REQ  = 2;
  localparam int CELL_LAT = 1;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_REQ-1:0]      req_valid, req_ready, req_hi, rsp_valid, rsp_ready;
  logic [NUM_REQ*32-1:0]   req_a, req_b;
  logic [31:0]             rsp_data, cell_src1, cell_src2, cell_p1, cell_p2, cell_p3;
  logic                    cell_en;

  mult_cell_sequencer #(.NUM_REQ(NUM_REQ), .CELL_LAT(CELL_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_hi(req_hi),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell model: clock-enabled capture, then CELL_LAT-1 free-running stages.
  logic [31:0] c1 [CELL_LAT];
  logic [31:0] c2 [CELL_LAT];
  logic [31:0] c3 [CELL_LAT];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < CELL_LAT; k++) begin
        c1[k] <= '0; c2[k] <= '0; c3[k] <= '0;
      end
    end else begin
      if (cell_en) begin
        c1[0] <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
        c2[0] <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
        c3[0] <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
      end
      for (int k = 1; k < CELL_LAT; k++) begin
        c1[k] <= c1[k-1]; c2[k] <= c2[k-1]; c3[k] <= c3[k-1];
      end
    end
  end
  assign cell_p1 = c1[CELL_LAT-1];
  assign cell_p2 = c2[CELL_LAT-1];
  assign cell_p3 = c3[CELL_LAT-1];

  typedef struct { logic [31:0] a; logic [31:0] b; logic hi; } op_t;
  typedef struct { int owner; logic [31:0] data; int acc_cyc; int lat; bit seen; } exp_t;

  op_t  pend [NUM_REQ][$];
  exp_t sb [$];
  int   total = 0, bad = 0, cyc = 0, rr_ptr = 0;
  int   pulses = 0, exp_pulses = 0;
  bit   prev_en = 1'b0, done = 1'b0, timed_out = 1'b0;

  function automatic void chk(input string nm, input longint unsigned act, input longint unsigned req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [NUM_REQ-1:0] acc;
    longint unsigned    prod;
    int                 win;
    bit                 hi_eff;
    exp_t               e;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_src1", cell_src1, 0);
        chk("reset_src2", cell_src2, 0);
        chk("reset_ctrl", {req_ready, rsp_valid, cell_en}, 0);
        sb.delete();
        rr_ptr  = 0;
        prev_en = 1'b0;
        continue;
      end
      chk("req_ready_onehot0", $onehot0(req_ready), 1);
      acc = req_valid & req_ready;
      if (acc != 0) begin
        win = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (win < 0 && req_valid[(rr_ptr + k) % NUM_REQ]) win = (rr_ptr + k) % NUM_REQ;
        chk("grant", acc, 64'(1) << win);
        prod = {32'h0, req_a[32*win +: 32]} * {32'h0, req_b[32*win +: 32]};
`ifdef MULT_SEQ_HI_EN
        hi_eff = req_hi[win];
`else
        hi_eff = 1'b0;
`endif
        e.owner   = win;
        e.data    = hi_eff ? prod[63:32] : prod[31:0];
        e.acc_cyc = cyc;
        e.lat     = hi_eff ? 2 * (1 + CELL_LAT) : 1 + CELL_LAT;
        e.seen    = 1'b0;
        sb.push_back(e);
        exp_pulses += hi_eff ? 2 : 1;
        rr_ptr = (win + 1) % NUM_REQ;
      end
      if (cell_en) begin
        pulses++;
        chk("cell_en_single_cycle", prev_en, 0);
      end
      prev_en = cell_en;
      if (rsp_valid != 0) begin
        chk("req_ready_in_resp", req_ready, 0);
        chk("cell_en_in_resp", cell_en, 0);
        if (sb.size() == 0) begin
          chk("spurious_rsp", rsp_valid, 0);
        end else begin
          if (!sb[0].seen) begin
            chk("latency", cyc, sb[0].acc_cyc + 1 + sb[0].lat);
            sb[0].seen = 1'b1;
          end
          chk("rsp_owner", rsp_valid, 64'(1) << sb[0].owner);
          chk("rsp_data", rsp_data, sb[0].data);
          if (rsp_ready[sb[0].owner]) void'(sb.pop_front());
        end
      end
    end
    chk("timeout", timed_out, 0);
    chk("sb_drained", sb.size(), 0);
    chk("cell_en_pulses", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic hi);
    op_t o;
    o.a = a; o.b = b; o.hi = hi;
    return o;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'hFFFFFFFF;
      1: return 32'h0;
      2: return {16'h0, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  // mode 0: rsp_ready all ones; 1: random; 2: held low for 5 response cycles
  task automatic run_phase(input int mode, input int vprob, input int budget);
    logic [NUM_REQ-1:0] acc;
    int  n = 0, hold = 0;
    bit  empty;
    op_t o;
    while (n < budget) begin
      empty = (req_valid == 0) && (sb.size() == 0) && (rsp_valid == 0);
      for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() != 0) empty = 1'b0;
      if (empty) break;
      @(negedge clk);
      acc = req_valid & req_ready;
      hold = (rsp_valid != 0) ? hold + 1 : 0;
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) begin
        req_valid[i]       = 1'b0;
        req_a[32*i +: 32]  = $urandom;
        req_b[32*i +: 32]  = $urandom;
        req_hi[i]          = 1'($urandom);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && pend[i].size() != 0 && $urandom_range(0, 99) < vprob) begin
          o = pend[i].pop_front();
          req_a[32*i +: 32] = o.a;
          req_b[32*i +: 32] = o.b;
          req_hi[i]         = o.hi;
          req_valid[i]      = 1'b1;
        end
      case (mode)
        0:       rsp_ready = '1;
        1:       rsp_ready = NUM_REQ'($urandom);
        default: rsp_ready = (hold >= 5) ? '1 : '0;
      endcase
    end
    if (n >= budget) timed_out = 1'b1;
  endtask

  // Stimulus
  initial begin
    logic [NUM_REQ-1:0] acc;
    bit got;
    reset_n = 1'b1; req_valid = '0; req_hi = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    pend[0].push_back(mk(32'd3, 32'd5, 1'b0));
    pend[0].push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0));
    pend[0].push_back(mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1));
    pend[0].push_back(mk(32'h00012345, 32'h00010000, 1'b1));
    pend[0].push_back(mk(32'h00012345, 32'h00010000, 1'b0));
    run_phase(0, 100, 200);

    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(mk(rnd_word(), rnd_word(), 1'($urandom)));
      pend[1].push_back(mk(rnd_word(), rnd_word(), 1'($urandom)));
    end
    run_phase(0, 100, 300);

    pend[0].push_back(mk(32'hDEADBEEF, 32'h12345678, 1'b0));
    pend[1].push_back(mk(32'h0000FFFF, 32'hFFFF0000, 1'b1));
    run_phase(2, 100, 300);

    // Reset while the operation sits in WAIT_LO.
    req_a[31:0] = 32'h1234; req_b[31:0] = 32'h5678; req_hi[0] = 1'b0; req_valid[0] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      got = acc[0];
    end
    if (!got) timed_out = 1'b1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1;

    pend[0].push_back(mk(32'd2, 32'd2, 1'b0));
    pend[1].push_back(mk(32'd3, 32'd7, 1'b0));
    run_phase(0, 100, 200);

    for (int k = 0; k < 60; k++)
      for (int i = 0; i < NUM_REQ; i++)
        pend[i].push_back(mk(rnd_word(), rnd_word(), 1'($urandom)));
    run_phase(1, 60, 8000);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule
